// File: rtl/dma_controller_if.sv
// dma_controller_if: data-memory port shared between the DMA engine and the
// top-level memory mux.
//   cpu_mem_ce  - CPU owns the data memory this cycle (DMA must stay off)
//   mem_ce      - DMA access this cycle; mux selects the DMA signals
//   mem_address - 30-bit word address
//   mem_wbe     - byte write enables (4'b1111 write, 4'b0000 read)
//   mem_wdata   - write data
//   mem_rdata   - read data, valid at the edge ending the read cycle
// Modports: master = DMA engine, slave = memory / mux side.
interface dma_controller_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  cpu_mem_ce;
    logic                  mem_ce;
    logic [29:0]           mem_address;
    logic [3:0]            mem_wbe;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  cpu_mem_ce, mem_rdata,
        output mem_ce, mem_address, mem_wbe, mem_wdata
    );

    modport slave (
        output cpu_mem_ce, mem_rdata,
        input  mem_ce, mem_address, mem_wbe, mem_wdata
    );
endinterface

// File: rtl/dma_controller.sv
// dma_controller: cycle-stealing memory-to-memory DMA engine. Copies COUNT
// 32-bit words from SRC to DST, using the data memory only in cycles where
// the CPU is not accessing it.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   data         - peripheral data bus (driven only on ce & !rw)
//   address      - register select (SRC, DST, COUNT, CTRL)
//   rw, ce       - 1 = write / register access enable
//   mem          - data-memory port (dma_controller_if.master)
//   irq          - level interrupt, done & irq_en
// CTRL: bit0 start, bit1 irq_en, bit2 busy, bit3 done (W1C), bit4 abort,
//       bit5 fill.
// Optional feature: define DMA_FILL_EN to enable fill mode (writes the SRC
// register value to every destination word, one word per cycle).
module dma_controller #(
    parameter int         DATA_WIDTH  = 32,
    parameter int         COUNT_WIDTH = 16,
    parameter logic [1:0] SRC_ADDR    = 2'b00,
    parameter logic [1:0] DST_ADDR    = 2'b01,
    parameter logic [1:0] COUNT_ADDR  = 2'b10,
    parameter logic [1:0] CTRL_ADDR   = 2'b11
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  logic [DATA_WIDTH-1:0] data,
    input  logic [1:0]            address,
    input  logic                  rw,
    input  logic                  ce,
    dma_controller_if.master      mem,
    output logic                  irq
);
    localparam int AW = DATA_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           src_q, dst_q;
    logic [COUNT_WIDTH-1:0]  count_q;
    logic [DATA_WIDTH-1:0]   buf_q;
    logic                    irq_en_q, done_q;
    logic [DATA_WIDTH-1:0]   rd_data;

    logic busy, reg_wr, wr_ctrl, start_req, abort_req;
    logic start_fill, fill_q;
    logic done_set, xfer_read, xfer_write;
    logic [DATA_WIDTH-1:0] write_word;

`ifdef DMA_FILL_EN
    logic [1:0] src_lo_q;
    assign start_fill = data[5];
    assign write_word = fill_q ? {src_q, src_lo_q} : buf_q;
`else
    assign start_fill = 1'b0;
    assign fill_q     = 1'b0;
    assign write_word = buf_q;
`endif

    assign busy      = (state_q != IDLE);
    assign reg_wr    = ce & rw;
    assign wr_ctrl   = reg_wr && (address == CTRL_ADDR);
    assign abort_req = wr_ctrl && data[4];
    // Abort wins over a simultaneous start.
    assign start_req = wr_ctrl && data[0] && !data[4] && !busy;

    always_comb begin
        state_d    = state_q;
        done_set   = 1'b0;
        xfer_read  = 1'b0;
        xfer_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_req) begin
                    if (count_q != '0) state_d = start_fill ? WRITE : READ;
                    else               done_set = 1'b1;
                end
            end
            READ: begin
                if (abort_req) state_d = IDLE;
                else if (!mem.cpu_mem_ce) begin
                    xfer_read = 1'b1;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (abort_req) state_d = IDLE;
                else if (!mem.cpu_mem_ce) begin
                    xfer_write = 1'b1;
                    if (count_q == COUNT_WIDTH'(1)) begin
                        state_d  = IDLE;
                        done_set = 1'b1;
                    end else begin
                        state_d = fill_q ? WRITE : READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory port: purely combinational; an access issued in an abort cycle
    // still reaches the memory, but the registers are left untouched.
    always_comb begin
        mem.mem_ce      = 1'b0;
        mem.mem_address = '0;
        mem.mem_wbe     = '0;
        mem.mem_wdata   = '0;
        if (busy && !mem.cpu_mem_ce) begin
            mem.mem_ce = 1'b1;
            if (state_q == READ) begin
                mem.mem_address = src_q;
            end else begin
                mem.mem_address = dst_q;
                mem.mem_wbe     = '1;
                mem.mem_wdata   = write_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            count_q  <= '0;
            buf_q    <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef DMA_FILL_EN
            src_lo_q <= '0;
            fill_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (reg_wr && !busy) begin
                case (address)
                    SRC_ADDR: begin
                        src_q <= data[DATA_WIDTH-1:2];
`ifdef DMA_FILL_EN
                        src_lo_q <= data[1:0];
`endif
                    end
                    DST_ADDR:   dst_q   <= data[DATA_WIDTH-1:2];
                    COUNT_ADDR: count_q <= data[COUNT_WIDTH-1:0];
                    default: ;
                endcase
            end
            if (wr_ctrl) irq_en_q <= data[1];
`ifdef DMA_FILL_EN
            if (wr_ctrl && !busy) fill_q <= data[5];
`endif
            if (done_set)                done_q <= 1'b1;
            else if (wr_ctrl && data[3]) done_q <= 1'b0;
            if (xfer_read) begin
                buf_q <= mem.mem_rdata;
                src_q <= src_q + AW'(1);
            end
            if (xfer_write) begin
                dst_q   <= dst_q + AW'(1);
                count_q <= count_q - COUNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (address)
            SRC_ADDR:   rd_data = {src_q, 2'b00};
            DST_ADDR:   rd_data = {dst_q, 2'b00};
            COUNT_ADDR: rd_data[COUNT_WIDTH-1:0] = count_q;
            default: begin
                rd_data[1] = irq_en_q;
                rd_data[2] = busy;
                rd_data[3] = done_q;
                rd_data[5] = fill_q;
            end
        endcase
    end

    assign data = (ce && !rw) ? rd_data : 'z;
    assign irq  = done_q & irq_en_q;
endmodule

// File: tb/tb_dma_controller.sv
// tb_dma_controller: directed scoreboard bench for dma_controller. Stimulus
// pushes expected memory accesses and register-read results into queues; a
// negedge monitor pops and compares whenever the DUT accesses memory or a
// register read is on the bus.
module tb_dma_controller;
    localparam logic [1:0] A_SRC = 2'b00, A_DST = 2'b01, A_CNT = 2'b10, A_CTRL = 2'b11;
    localparam logic [31:0] SRC_WORDS [4] = '{32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 32'h0BADC0DE};

    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  wbe;
        logic [31:0] wdata;
    } acc_t;

    typedef struct packed {
        logic [31:0] d;
        logic        irq;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst;
    wire  [31:0] data;
    logic [31:0] drv;
    logic        oe;
    logic [1:0]  address;
    logic        rw, ce, irq;
    logic        init_mem;
    logic [31:0] mem_arr [0:1023];

    acc_t mq[$];
    rd_t  rq[$];
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    assign data = oe ? drv : 'z;

    dma_controller_if #(.DATA_WIDTH(32)) mem_if ();

    dma_controller #(.DATA_WIDTH(32), .COUNT_WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .data    (data),
        .address (address),
        .rw      (rw),
        .ce      (ce),
        .mem     (mem_if),
        .irq     (irq)
    );

    assign mem_if.mem_rdata = mem_arr[mem_if.mem_address[9:0]];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) mem_arr[i] <= 32'h0;
            for (int k = 0; k < 4; k++) mem_arr[10'h100 + k] <= SRC_WORDS[k];
            mem_arr[10'h3FF] <= 32'h11112222;
            mem_arr[0]       <= 32'h33334444;
        end else if (mem_if.mem_ce && mem_if.mem_wbe == 4'hF) begin
            mem_arr[mem_if.mem_address[9:0]] <= mem_if.mem_wdata;
        end
    end

    function automatic void check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endfunction

    function automatic void push_acc(input logic [29:0] a, input logic [3:0] w, input logic [31:0] d);
        mq.push_back({a, w, d});
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (mem_if.mem_ce) begin
            if (mq.size() == 0) begin
                n_checks++;
                $display("FAIL mem_access: unexpected access addr=0x%0h wbe=0x%0h wdata=0x%0h",
                         mem_if.mem_address, mem_if.mem_wbe, mem_if.mem_wdata);
            end else begin
                check("mem_access", {mem_if.mem_address, mem_if.mem_wbe, mem_if.mem_wdata}, mq.pop_front());
            end
        end
        if (mem_if.cpu_mem_ce) check("mem_ce_overlap", 66'(mem_if.mem_ce), 66'(0));
        if (ce && !rw) begin
            if (rq.size() == 0) begin
                n_checks++;
                $display("FAIL reg_read: unexpected read addr=%0d data=0x%0h", address, data);
            end else begin
                check("reg_read", {data, irq}, rq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        ce = 1'b1; rw = 1'b1; address = a; drv = v; oe = 1'b1;
        tick();
        ce = 1'b0; rw = 1'b0; oe = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] d, input logic i);
        rq.push_back({d, i});
        ce = 1'b1; rw = 1'b0; address = a;
        tick();
        ce = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ce = 1'b0; rw = 1'b0; oe = 1'b0; drv = '0; address = '0;
        mem_if.cpu_mem_ce = 1'b0;
        init_mem = 1'b1;
        idle(3);
        #0;
        rst = 1'b0; init_mem = 1'b0;

        // Power-on reset values
        rd(A_CTRL, 32'h0, 1'b0);
        rd(A_CNT,  32'h0, 1'b0);
        rd(A_SRC,  32'h0, 1'b0);

        // Reset mid-transfer (COUNT=8): accesses through cycle 4 then nothing
        wr(A_SRC, 32'h400);
        wr(A_DST, 32'hC00);
        wr(A_CNT, 32'd8);
        push_acc(30'h100, 4'h0, 32'h0);
        push_acc(30'h300, 4'hF, SRC_WORDS[0]);
        push_acc(30'h101, 4'h0, 32'h0);
        push_acc(30'h301, 4'hF, SRC_WORDS[1]);
        wr(A_CTRL, 32'h3);
        idle(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd(A_CTRL, 32'h0, 1'b0);
        rd(A_CNT,  32'h0, 1'b0);
        idle(4);
        check("reset_no_access", 66'(mq.size()), 66'(0));

        // Basic copy 0x100..0x103 -> 0x200..0x203
        wr(A_SRC, 32'h400);
        wr(A_DST, 32'h800);
        wr(A_CNT, 32'd4);
        for (int k = 0; k < 4; k++) begin
            push_acc(30'h100 + 30'(k), 4'h0, 32'h0);
            push_acc(30'h200 + 30'(k), 4'hF, SRC_WORDS[k]);
        end
        wr(A_CTRL, 32'h3);          // cycle 0
        wr(A_SRC, 32'h0);           // cycle 1, ignored while busy
        idle(6);                    // cycles 2..7
        rd(A_CTRL, 32'h6, 1'b0);    // cycle 8: still busy
        rd(A_CTRL, 32'hA, 1'b1);    // cycle 9: done, irq
        rd(A_CNT,  32'h0, 1'b1);
        rd(A_SRC,  32'h410, 1'b1);
        rd(A_DST,  32'h810, 1'b1);
        check("copy_drained", 66'(mq.size()), 66'(0));

        // Done clear, then zero-count start
        wr(A_CTRL, 32'h8);
        rd(A_CTRL, 32'h0, 1'b0);
        wr(A_CNT, 32'd0);
        wr(A_CTRL, 32'h1);
        rd(A_CTRL, 32'h8, 1'b0);
        idle(2);

        // Address wrap: SRC word 0x3FFFFFFF, COUNT=2
        wr(A_CTRL, 32'h8);
        wr(A_SRC, 32'hFFFFFFFC);
        wr(A_DST, 32'h140);
        wr(A_CNT, 32'd2);
        push_acc(30'h3FFFFFFF, 4'h0, 32'h0);
        push_acc(30'h50,       4'hF, 32'h11112222);
        push_acc(30'h0,        4'h0, 32'h0);
        push_acc(30'h51,       4'hF, 32'h33334444);
        wr(A_CTRL, 32'h1);
        idle(4);
        rd(A_CTRL, 32'h8,   1'b0);
        rd(A_SRC,  32'h4,   1'b0);
        rd(A_DST,  32'h148, 1'b0);

        // Contention: cpu_mem_ce high on odd cycles 1..15
        wr(A_CTRL, 32'h8);
        wr(A_SRC, 32'h400);
        wr(A_DST, 32'h900);
        wr(A_CNT, 32'd4);
        for (int k = 0; k < 4; k++) begin
            push_acc(30'h100 + 30'(k), 4'h0, 32'h0);
            push_acc(30'h240 + 30'(k), 4'hF, SRC_WORDS[k]);
        end
        wr(A_CTRL, 32'h3);
        for (int c = 1; c <= 15; c++) begin
            mem_if.cpu_mem_ce = c[0];
            tick();
        end
        mem_if.cpu_mem_ce = 1'b0;
        rd(A_CTRL, 32'h6, 1'b0);    // cycle 16
        rd(A_CTRL, 32'hA, 1'b1);    // cycle 17
        rd(A_CNT,  32'h0, 1'b1);

        // Abort after 3 words of a 10-word copy
        wr(A_CTRL, 32'h8);
        wr(A_SRC, 32'h400);
        wr(A_DST, 32'h980);
        wr(A_CNT, 32'd10);
        for (int k = 0; k < 3; k++) begin
            push_acc(30'h100 + 30'(k), 4'h0, 32'h0);
            push_acc(30'h260 + 30'(k), 4'hF, SRC_WORDS[k]);
        end
        push_acc(30'h103, 4'h0, 32'h0);  // read issued in the abort cycle
        wr(A_CTRL, 32'h3);
        idle(6);
        wr(A_CTRL, 32'h10);         // cycle 7
        rd(A_CTRL, 32'h0,   1'b0);
        rd(A_CNT,  32'd7,   1'b0);
        rd(A_SRC,  32'h40C, 1'b0);
        rd(A_DST,  32'h98C, 1'b0);
        idle(4);
        check("abort_drained", 66'(mq.size()), 66'(0));

`ifdef DMA_FILL_EN
        wr(A_CTRL, 32'h8);
        wr(A_SRC, 32'hA5A5A5A4);
        wr(A_DST, 32'h40);
        wr(A_CNT, 32'd3);
        for (int k = 0; k < 3; k++) push_acc(30'h10 + 30'(k), 4'hF, 32'hA5A5A5A4);
        wr(A_CTRL, 32'h21);
        idle(2);
        rd(A_CTRL, 32'h24, 1'b0);   // cycle 3: last write
        rd(A_CTRL, 32'h28, 1'b0);   // cycle 4: done
        rd(A_SRC,  32'hA5A5A5A4, 1'b0);
`else
        wr(A_CTRL, 32'h20);
        rd(A_CTRL, 32'h0, 1'b0);
`endif

        idle(2);
        check("mem_queue_empty", 66'(mq.size()), 66'(0));
        check("read_queue_empty", 66'(rq.size()), 66'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dma_controller.md
# dma_controller

Memory-to-memory DMA engine for the MIPS microcontroller. It copies blocks of 32-bit words inside the data memory by cycle-stealing: it uses the data-memory port only in cycles where the CPU is not accessing it. The CPU configures it through a four-register slave on the peripheral controller, and an interrupt request goes to the interrupt controller when a transfer completes.

## Interface
Parameters:
- DATA_WIDTH, 32, register and memory data width.
- COUNT_WIDTH, 16, width of the word-count register.
- SRC_ADDR, 2'b00, source word-address register.
- DST_ADDR, 2'b01, destination word-address register.
- COUNT_ADDR, 2'b10, remaining-word-count register.
- CTRL_ADDR, 2'b11, control/status register.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- data  inout  32  peripheral data bus; driven only when ce=1 and rw=0, otherwise high-Z.
- address  in  2  register select.
- rw  in  1  1 = write, 0 = read.
- ce  in  1  register access enable.
- cpu_mem_ce  in  1  CPU data-memory access this cycle; while high, DMA memory outputs stay 0.
- mem_ce  out  1  DMA memory access this cycle; the top-level mux selects DMA signals when this is high.
- mem_address  out  30  word address.
- mem_wbe  out  4  4'b1111 on DMA writes, 4'b0000 on DMA reads.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data; valid at the rising edge that ends the read cycle.
- irq  out  1  level interrupt.

## Operation
Registers:
- SRC and DST hold 30-bit word addresses in bits [31:2]; bits [1:0] read 0.
- COUNT holds the remaining word count and updates live.
- CTRL is bit-mapped:
  - bit0 start: write-1 pulse; reads 0.
  - bit1 irq_en.
  - bit2 busy: read-only.
  - bit3 done: sticky; write 1 to clear.
  - bit4 abort: write-1 pulse.
  - bit5 fill.
- While busy, writes to SRC, DST and COUNT are ignored. A CTRL write while busy still updates irq_en, done-clear and abort; start is ignored.

FSM states are IDLE, READ, WRITE.
- IDLE → READ on start with COUNT≠0; busy=1 from the next cycle.
- Start with COUNT=0: done is set at the next edge, no memory access, state stays IDLE.
- READ: when cpu_mem_ce=0, the block drives mem_ce=1, mem_wbe=0, mem_address=SRC. At the end of that cycle it latches mem_rdata into a buffer, increments SRC and goes to WRITE. While cpu_mem_ce=1 it waits in READ.
- WRITE: when cpu_mem_ce=0, the block drives mem_ce=1, mem_wbe=1111, mem_address=DST, mem_wdata=buffer. It then increments DST and decrements COUNT. If the new COUNT is 0 it sets done and goes to IDLE; otherwise it goes to READ.
- Addresses increment modulo 2^30 and wrap from 0x3FFFFFFF to 0.
- Abort: the FSM goes to IDLE at the next edge. done is not set, and SRC, DST and COUNT keep their current values. A memory access issued in the same cycle as the abort write still completes; no further accesses are issued.
- irq = done & irq_en, combinational from registered state.
- Memory outputs are combinational from state and cpu_mem_ce; they are zero in IDLE.
- Reset: FSM=IDLE; SRC, DST, COUNT, CTRL = 0; buffer = 0; mem_* = 0; irq = 0; data high-Z. Reset mid-transfer abandons the transfer immediately.

## Timing
- A register write takes effect at the rising edge of the ce/rw cycle. Register reads are combinational.
- Start written in cycle 0 → first READ access can occur in cycle 1.
- With no CPU contention, each word takes exactly 2 cycles. An N-word copy finishes with done=1 after the edge ending cycle 2N.
- Each cycle with cpu_mem_ce=1 while in READ or WRITE adds exactly one cycle.
- mem_ce and cpu_mem_ce are never both high.

## Configuration
- DMA_FILL_EN defined: CTRL bit5 is writable. When fill=1, the READ state is skipped, and each WRITE stores the SRC register value (full 32 bits, as written) to DST. SRC does not increment, and each word takes 1 cycle.
- DMA_FILL_EN undefined: bit5 reads 0, writes to it are ignored, and the fill logic is absent.

## Test plan
- Reset values: assert rst mid-transfer of COUNT=8 → next cycle busy=0, mem_ce=0, COUNT=0, irq=0, data high-Z.
- Basic copy: preload mem[0x100..0x103]; set SRC=0x400, DST=0x800, COUNT=4, CTRL=0x3 → mem[0x200..0x203] matches the source, done=1 and irq=1 at cycle 8, COUNT=0.
- Contention: same as basic copy with cpu_mem_ce high on alternate cycles → mem_ce never overlaps it, done at cycle 16, data correct.
- Zero count and wrap:
  - COUNT=0 with start → done at the next edge, no mem_ce.
  - SRC word 0x3FFFFFFF, COUNT=2 → second read address is 0.
- Abort: COUNT=10, write abort after 3 words → IDLE, done=0, COUNT=7, no mem_ce afterwards.
- Fill (DMA_FILL_EN): SRC=0xA5A5A5A4, DST=0x40, COUNT=3, fill=1 → words 0x10..0x12 = 0xA5A5A5A4, done at cycle 3.
